// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register indices, ExcCodes, Status/Cause bit positions and reset values.
package cp0_pkg;
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_IM_LO = 8;
    localparam int ST_BEV   = 22;
    localparam int CA_IP_LO = 8;

    localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    function automatic logic is_addr_exc(input logic [4:0] code);
        return code == EXC_ADEL || code == EXC_ADES;
    endfunction
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: prescaled Count, Compare and the sticky timer interrupt TI.
module cp0_timer #(
    parameter int TIMER_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_count_we,
    input  logic        i_compare_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_ti
);
    localparam int PW = TIMER_DIV > 1 ? $clog2(TIMER_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TIMER_DIV - 1);

    logic [PW-1:0] r_pre;
    logic [31:0]   r_count, r_compare, w_count_next;
    logic          r_ti, w_wrap, w_upd;

    assign w_wrap       = r_pre == PRE_MAX;
    assign w_upd        = i_count_we | w_wrap;
    assign w_count_next = i_count_we ? i_wdata : r_count + 32'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre     <= '0;
            r_count   <= '0;
            r_compare <= '0;
            r_ti      <= 1'b0;
        end else begin
            r_pre <= w_upd ? '0 : r_pre + 1'b1;
            if (w_upd) r_count <= w_count_next;
            if (i_compare_we) r_compare <= i_wdata;
            // A Compare write acknowledges TI and beats a same-cycle match
            r_ti <= i_compare_we ? 1'b0 : r_ti | (w_upd && w_count_next == r_compare);
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ti      = r_ti;
endmodule

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: MIPS CP0 registers with commit-point exception, ERET and interrupt resolution
// and a registered flush/redirect to fetch.
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter int          NUM_HW_INT = 6,
    parameter int          TIMER_DIV  = 2,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  commit_valid,
    input  logic [31:0]           commit_pc,
    input  logic [31:0]           commit_badvaddr,
    input  logic [4:0]            commit_exccode,
    input  logic                  commit_is_exc,
    input  logic                  commit_in_ds,
    input  logic                  commit_is_eret,
    input  logic [NUM_HW_INT-1:0] hw_int,
    input  logic                  wen,
    input  logic [4:0]            waddr,
    input  logic [31:0]           wdata,
    input  logic [4:0]            raddr,
    output logic [31:0]           rdata,
    output logic                  flush,
    output logic [31:0]           flush_pc,
    output logic [31:0]           status,
    output logic [31:0]           cause,
    output logic [31:0]           epc,
    output logic                  timer_int
);
    logic [NUM_HW_INT-1:0] r_hw_s1, r_hw_s2;
    logic [31:0] r_badvaddr, r_status, r_epc, r_flush_pc;
    logic [4:0]  r_exccode;
    logic [1:0]  r_ip_sw;
    logic        r_bd, r_flush;
    logic [31:0] w_count, w_compare, w_cause, w_epc_next;
    logic [7:0]  w_ip;
    logic        w_ti, w_commit, w_int_pending, w_take_exc, w_take_eret, w_take_int, w_enter, w_mtc0;

    always_comb begin
        w_ip = {6'b0, r_ip_sw};
        for (int i = 0; i < NUM_HW_INT && i < 5; i++) w_ip[2+i] = r_hw_s2[i];
        w_ip[7] = (NUM_HW_INT == 6) ? (w_ti | r_hw_s2[NUM_HW_INT-1]) : w_ti;
    end

    // The commit right after a flush belongs to the squashed path
    assign w_commit      = commit_valid & ~r_flush;
    assign w_int_pending = r_status[ST_IE] & ~r_status[ST_EXL] & |(w_ip & r_status[ST_IM_LO +: 8]);
    assign w_take_exc    = w_commit & commit_is_exc;
    assign w_take_eret   = w_commit & commit_is_eret & ~commit_is_exc;
    assign w_take_int    = w_commit & w_int_pending & ~commit_is_exc & ~commit_is_eret;
    assign w_mtc0        = w_commit & wen & ~commit_is_exc & ~commit_is_eret & ~w_int_pending;
    assign w_enter       = w_take_int | (w_take_exc & ~r_status[ST_EXL]);
    assign w_epc_next    = commit_in_ds ? commit_pc - 32'd4 : commit_pc;

    cp0_timer #(.TIMER_DIV(TIMER_DIV)) u_timer (
        .clk          (clk),
        .reset        (reset),
        .i_count_we   (w_mtc0 && waddr == REG_COUNT),
        .i_compare_we (w_mtc0 && waddr == REG_COMPARE),
        .i_wdata      (wdata),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_ti         (w_ti)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hw_s1    <= '0;
            r_hw_s2    <= '0;
            r_badvaddr <= '0;
            r_status   <= STATUS_RST;
            r_epc      <= '0;
            r_exccode  <= '0;
            r_ip_sw    <= '0;
            r_bd       <= 1'b0;
            r_flush    <= 1'b0;
            r_flush_pc <= '0;
        end else begin
            r_hw_s1    <= hw_int;
            r_hw_s2    <= r_hw_s1;
            r_flush    <= w_take_exc | w_take_eret | w_take_int;
            r_flush_pc <= w_take_eret ? r_epc : (w_take_exc | w_take_int) ? EXC_VECTOR : '0;
            if (w_enter) begin
                r_epc <= w_epc_next;
                r_bd  <= commit_in_ds;
            end else if (w_mtc0 && waddr == REG_EPC) begin
                r_epc <= wdata;
            end
            if (w_take_exc | w_take_int) begin
                r_exccode        <= w_take_exc ? commit_exccode : EXC_INT;
                r_status[ST_EXL] <= 1'b1;
            end else if (w_take_eret) begin
                r_status[ST_EXL] <= 1'b0;
            end else if (w_mtc0 && waddr == REG_STATUS) begin
                r_status <= (r_status & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
            end
            if (w_take_exc && is_addr_exc(commit_exccode)) r_badvaddr <= commit_badvaddr;
            if (w_mtc0 && waddr == REG_CAUSE) r_ip_sw <= wdata[CA_IP_LO +: 2];
        end
    end

    assign w_cause = {r_bd, w_ti, 14'b0, w_ip, 1'b0, r_exccode, 2'b0};

    assign rdata = raddr == REG_BADVADDR ? r_badvaddr :
                   raddr == REG_COUNT    ? w_count    :
                   raddr == REG_COMPARE  ? w_compare  :
                   raddr == REG_STATUS   ? r_status   :
                   raddr == REG_CAUSE    ? w_cause    :
                   raddr == REG_EPC      ? r_epc      : 32'd0;

    assign flush     = r_flush;
    assign flush_pc  = r_flush_pc;
    assign status    = r_status;
    assign cause     = w_cause;
    assign epc       = r_epc;
    assign timer_int = w_ti;
endmodule

// File: tb/tb_cp0_ctrl.sv
// tb_cp0_ctrl: randomized and directed CP0 checks against a transaction-level reference
// model; expected redirects are queued and matched by a flush monitor.
module tb_cp0_ctrl;
    localparam int          DIV = 2;
    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk = 1'b0, reset = 1'b0;
    logic        commit_valid, commit_is_exc, commit_in_ds, commit_is_eret, wen;
    logic [31:0] commit_pc, commit_badvaddr, wdata;
    logic [4:0]  commit_exccode, waddr, raddr;
    logic [5:0]  hw_int;
    logic [31:0] rdata, flush_pc, status, cause, epc;
    logic        flush, timer_int;

    always #5 clk = ~clk;

    cp0_ctrl #(.NUM_HW_INT(6), .TIMER_DIV(DIV), .EXC_VECTOR(VEC)) dut (
        .clk(clk), .reset(reset), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_badvaddr(commit_badvaddr), .commit_exccode(commit_exccode),
        .commit_is_exc(commit_is_exc), .commit_in_ds(commit_in_ds),
        .commit_is_eret(commit_is_eret), .hw_int(hw_int), .wen(wen), .waddr(waddr),
        .wdata(wdata), .raddr(raddr), .rdata(rdata), .flush(flush), .flush_pc(flush_pc),
        .status(status), .cause(cause), .epc(epc), .timer_int(timer_int)
    );

    int          n_cmp = 0, n_bad = 0, cyc = 0, m_nL = 0;
    logic [31:0] sb[$];
    logic [31:0] m_badv, m_compare, m_epc, m_L;
    logic [7:0]  m_im;
    logic [4:0]  m_exc;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_hw1, m_hw2;
    logic        m_exl, m_ie, m_bd, m_ti, m_flushed;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] cnt();
        return m_L + 32'((cyc - m_nL) / DIV);
    endfunction

    function automatic logic [7:0] mip();
        return {m_ti | m_hw2[5], m_hw2[4:0], m_ipsw};
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] a);
        case (a)
            5'd8:  return m_badv;
            5'd9:  return cnt();
            5'd11: return m_compare;
            5'd12: return {9'b0, 1'b1, 6'b0, m_im, 6'b0, m_exl, m_ie};
            5'd13: return {m_bd, m_ti, 14'b0, mip(), 1'b0, m_exc, 2'b0};
            5'd14: return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void minit();
        {m_badv, m_compare, m_epc, m_L} = '0;
        {m_im, m_exc, m_ipsw, m_hw1, m_hw2} = '0;
        {m_exl, m_ie, m_bd, m_ti, m_flushed} = '0;
        sb.delete();
    endfunction

    task automatic clr();
        {commit_valid, commit_is_exc, commit_in_ds, commit_is_eret, wen} = '0;
        {commit_pc, commit_badvaddr, wdata, commit_exccode, waddr} = '0;
    endtask

    // One clock: resolve the commit by the priority rules, queue any redirect, advance the model
    task automatic tick();
        logic cv, ex, er, tk, mt;
        @(posedge clk);
        cyc++;
        cv = commit_valid && !m_flushed;
        ex = cv && commit_is_exc;
        er = cv && commit_is_eret && !ex;
        tk = cv && !ex && !er && m_ie && !m_exl && (mip() & m_im) != 0;
        mt = cv && wen && !ex && !er && !tk;
        if (ex || er || tk) sb.push_back(er ? m_epc : VEC);
        m_flushed = ex || er || tk;
        m_hw2 = m_hw1;
        m_hw1 = hw_int;
        if ((ex || tk) && !m_exl) begin
            m_epc = commit_in_ds ? commit_pc - 32'd4 : commit_pc;
            m_bd  = commit_in_ds;
        end
        if (ex || tk) begin
            m_exc = ex ? commit_exccode : 5'd0;
            m_exl = 1'b1;
        end
        if (ex && (commit_exccode == 5'd4 || commit_exccode == 5'd5)) m_badv = commit_badvaddr;
        if (er) m_exl = 1'b0;
        if (mt)
            case (waddr)
                5'd9:  begin m_L = wdata; m_nL = cyc; end
                5'd11: m_compare = wdata;
                5'd12: begin m_im = wdata[15:8]; m_exl = wdata[1]; m_ie = wdata[0]; end
                5'd13: m_ipsw = wdata[9:8];
                5'd14: m_epc = wdata;
                default: ;
            endcase
        if (mt && waddr == 5'd11) m_ti = 1'b0;
        else if ((cyc - m_nL) % DIV == 0 && cnt() == m_compare) m_ti = 1'b1;
        #1;
    endtask

    task automatic cmt(input logic [31:0] pc, input logic exc, ds, eret, input logic [4:0] code,
                       input logic [31:0] badv, input logic we, input logic [4:0] wa, input logic [31:0] wd);
        commit_valid = 1'b1; commit_pc = pc; commit_is_exc = exc; commit_in_ds = ds;
        commit_is_eret = eret; commit_exccode = code; commit_badvaddr = badv;
        wen = we; waddr = wa; wdata = wd;
        tick();
        clr();
    endtask

    task automatic mtc0(input logic [4:0] wa, input logic [31:0] wd);
        cmt(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, wa, wd);
    endtask

    task automatic rd(input logic [4:0] a);
        raddr = a;
        #1;
        chk($sformatf("rdata[%0d]", a), rdata, mread(a));
    endtask

    task automatic outs();
        chk("status", status, mread(5'd12));
        chk("cause", cause, mread(5'd13));
        chk("epc", epc, m_epc);
        chk("timer_int", 32'(timer_int), 32'(m_ti));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        minit();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        m_nL = cyc;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            logic pend;
            pend = sb.size() != 0;
            chk("flush", 32'(flush), 32'(pend));
            if (pend && flush) chk("flush_pc", flush_pc, sb.pop_front());
            else if (pend) void'(sb.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    logic [4:0] codes[7] = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};
    logic [4:0] regs[7]  = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};

    initial begin
        clr();
        hw_int = '0;
        raddr  = '0;
        do_reset();
        rd(5'd12);
        chk("status_rst", rdata, 32'h0040_0000);
        rd(5'd13);
        chk("cause_rst", rdata, 32'h0);
        chk("flush_rst", 32'(flush), 32'd0);
        repeat (10) tick();
        rd(5'd9);
        chk("count_after_10", rdata, 32'd5);

        // Timer interrupt
        mtc0(5'd11, 32'd3);
        mtc0(5'd9, 32'd0);
        mtc0(5'd12, 32'h0000_8001);
        for (int k = 0; k < 20 && !timer_int; k++) tick();
        chk("ti_rise", 32'(timer_int), 32'd1);
        rd(5'd9);
        chk("count_at_ti", rdata, 32'd3);
        cmt(32'h100, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("int_flush_pc", flush_pc, VEC);
        chk("int_epc", epc, 32'h100);
        chk("int_exccode", 32'(cause[6:2]), 32'd0);
        mtc0(5'd11, 32'hFFFF_0000);
        chk("ti_post_flush_write_ignored", 32'(timer_int), 32'd1);
        mtc0(5'd11, 32'hFFFF_0000);
        chk("ti_cleared", 32'(timer_int), 32'd0);
        outs();

        // AdEL in a delay slot
        mtc0(5'd12, 32'h0);
        cmt(32'h204, 1'b1, 1'b1, 1'b0, 5'd4, 32'h1001, 1'b0, 5'd0, 32'h0);
        tick();
        chk("adel_epc", epc, 32'h200);
        chk("adel_bd", 32'(cause[31]), 32'd1);
        chk("adel_exl", 32'(status[1]), 32'd1);
        rd(5'd8);
        chk("adel_badvaddr", rdata, 32'h1001);

        // Nested exception, then ERET
        cmt(32'h300, 1'b1, 1'b0, 1'b0, 5'd10, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        chk("nested_epc", epc, 32'h200);
        chk("nested_exccode", 32'(cause[6:2]), 32'd10);
        cmt(32'h308, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("eret_flush_pc", flush_pc, 32'h200);
        tick();
        chk("eret_exl", 32'(status[1]), 32'd0);

        // Exception beats pending interrupt and same-cycle MTC0
        mtc0(5'd12, 32'h0000_0101);
        mtc0(5'd13, 32'h0000_0100);
        cmt(32'h320, 1'b1, 1'b0, 1'b0, 5'd8, 32'h0, 1'b1, 5'd12, 32'h0);
        tick();
        chk("prio_exccode", 32'(cause[6:2]), 32'd8);
        chk("prio_status_kept", 32'(status[0]), 32'd1);
        outs();
        mtc0(5'd13, 32'h0);
        cmt(32'h324, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();

        // Hardware interrupt through the synchroniser
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001;
        tick();
        chk("ip2_after_1", 32'(cause[10]), 32'd0);
        tick();
        chk("ip2_after_2", 32'(cause[10]), 32'd1);
        tick();
        hw_int = '0;
        cmt(32'h400, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("hw_int_flush", 32'(flush), 32'd1);
        tick();
        chk("hw_epc", epc, 32'h400);
        outs();
        cmt(32'h404, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();

        // Reset while a flush is showing
        cmt(32'h500, 1'b1, 1'b0, 1'b0, 5'd12, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("reset_flush", 32'(flush), 32'd0);
        raddr = 5'd9;
        #1;
        chk("reset_count", rdata, 32'd0);
        do_reset();
        outs();

        for (int it = 0; it < 400; it++) begin
            int op;
            if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom);
            op = $urandom_range(0, 9);
            if (op < 3) begin
                tick();
            end else if (op < 8) begin
                logic [4:0] wa;
                logic [31:0] wd;
                wa = regs[$urandom_range(0, 6)];
                wd = $urandom;
                if (wa == 5'd11 && $urandom_range(0, 1) == 1) wd = cnt() + $urandom_range(0, 4);
                if (op < 6)
                    cmt($urandom & ~32'h3, $urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 5) == 0,
                        codes[$urandom_range(0, 6)], $urandom, 1'($urandom), wa, wd);
                else
                    mtc0(wa, wd);
            end else begin
                rd(regs[$urandom_range(0, 6)]);
                rd(5'($urandom));
                outs();
            end
        end
        repeat (3) tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
